// File: rtl/hazard_stall_unit.sv
// Pipeline hold/bubble/flush control for load-use and branch-register hazards
// and I/D-cache misses, with a miss watchdog and a saturating stall counter.
module hazard_stall_unit #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       if_id_rs,
  input  logic [3:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             if_id_branch_reg,
  input  logic             if_id_branch_taken,
  input  logic [3:0]       id_ex_rd,
  input  logic             id_ex_write_reg,
  input  logic             id_ex_mem_read,
  input  logic [3:0]       ex_mem_rd,
  input  logic             ex_mem_write_reg,
  input  logic             ex_mem_mem_read,
  input  logic             imiss_req,
  input  logic             imiss_done,
  input  logic             dmiss_req,
  input  logic             dmiss_done,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_bubble,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             miss_err
);

  localparam int unsigned WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              imiss_pend_q, imiss_pend_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              miss_err_q, miss_err_d;
  logic              lu, brh, hz;

  // Register 0 is hardwired, so it never creates a dependency.
  assign lu  = id_ex_mem_read & id_ex_write_reg & (id_ex_rd != 4'd0) &
               ((id_ex_rd == if_id_rs) | (if_id_uses_rt & (id_ex_rd == if_id_rt)));
  assign brh = if_id_branch_reg & (if_id_rs != 4'd0) &
               ((id_ex_write_reg & (id_ex_rd == if_id_rs)) |
                (ex_mem_write_reg & ex_mem_mem_read & (ex_mem_rd == if_id_rs)));
  assign hz  = lu | brh;

  // Miss sequencing: a D-miss preempts an I-miss and the I-miss resumes afterwards.
  always_comb begin
    state_d      = state_q;
    imiss_pend_d = imiss_pend_q;
    case (state_q)
      RUN: begin
        if (dmiss_req)      state_d = DMISS;
        else if (imiss_req) state_d = IMISS;
      end
      IMISS: begin
        if (dmiss_req) begin
          state_d      = DMISS;
          imiss_pend_d = ~imiss_done;
        end else if (imiss_done) begin
          state_d = RUN;
        end
      end
      DMISS: begin
        if (dmiss_done) begin
          state_d      = (imiss_pend_q | imiss_req) ? IMISS : RUN;
          imiss_pend_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Mealy pipeline controls; everything is held low while in reset.
  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (hz) begin
            id_ex_bubble = 1'b1;
          end else begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = if_id_branch_taken;
          end
        end
        IMISS: begin
          if_id_bubble = ~hz;
          if_id_we     = ~hz;
          id_ex_bubble = hz;
        end
        DMISS:   pipe_freeze = 1'b1;
        default: pipe_freeze = 1'b0;
      endcase
    end
  end

  // Watchdog restarts on every state change and saturates at TIMEOUT.
  always_comb begin
    wdog_d     = wdog_q;
    miss_err_d = miss_err_q;
    stall_d    = stall_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if ((state_q != RUN) && (wdog_q != WDOG_W'(TIMEOUT))) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    if ((state_q != RUN) && (wdog_q == WDOG_W'(TIMEOUT))) begin
      miss_err_d = 1'b1;
    end
    if (!pc_we && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      wdog_q       <= '0;
      imiss_pend_q <= 1'b0;
      stall_q      <= '0;
      miss_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      imiss_pend_q <= imiss_pend_d;
      stall_q      <= stall_d;
      miss_err_q   <= miss_err_d;
    end
  end

  assign stall_cycles = stall_q;
  assign miss_err     = miss_err_q;

endmodule
